// File: rtl/onchip_mem_stream_reader.sv
// Streams a contiguous block of on-chip memory words out of an Avalon-ST source.
// Reads are issued only while the output buffer has room for every in-flight word.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_startofpacket,
  output logic              st_endofpacket
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   issue_left_q;
  logic [ADDR_W:0]   beats_left_q;
  logic              first_q;
  logic              done_q;
  logic              vld_p1;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  occ;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic start_ok, zero_start, issue_p0, accept, last_accept, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok)    state_d = RUN;
      RUN:  if (last_accept) state_d = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q == RUN);
    done             = done_q;
    mem_address      = addr_q;
    mem_clken        = 1'b1;
    st_valid         = (count_q != '0);
    st_data          = st_valid ? fifo_mem[rd_ptr_q] : '0;
    st_startofpacket = st_valid & first_q;
    st_endofpacket   = st_valid & (beats_left_q == LEN_ONE);
    accept           = st_valid & st_ready;
    last_accept      = accept & st_endofpacket;
    start_ok         = (state_q == IDLE) & start & (length != '0);
    zero_start       = (state_q == IDLE) & start & (length == '0);
    done_d           = zero_start | (busy & last_accept);
    // Words already buffered plus the one read still in flight bound the next issue.
    occ              = count_q + CNT_W'(vld_p1);
    issue_p0         = busy & (issue_left_q != '0) & (occ < DEPTH_C);
    mem_chipselect   = issue_p0;
  end

  // Issue stage (p0): address and transfer bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
      vld_p1       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      done_q <= done_d;
      vld_p1 <= issue_p0;
      if (start_ok) begin
        addr_q       <= base_addr;
        issue_left_q <= length;
        beats_left_q <= length;
        first_q      <= 1'b1;
      end else begin
        if (issue_p0) begin
          addr_q       <= addr_q + ADR_ONE;
          issue_left_q <= issue_left_q - LEN_ONE;
        end
        if (accept) begin
          beats_left_q <= beats_left_q - LEN_ONE;
          first_q      <= 1'b0;
        end
      end
      if (vld_p1) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (accept) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({vld_p1, accept})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Capture stage (p1): read data returns one cycle after issue
  always_ff @(posedge clk) begin
    if (vld_p1) fifo_mem[wr_ptr_q] <= mem_readdata;
  end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench for onchip_mem_stream_reader: a memory model answers reads,
// a negedge monitor compares beats, read addresses, busy and done against a reference.
module tb_onchip_mem_stream_reader;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_startofpacket;
  logic              st_endofpacket;

  onchip_mem_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_startofpacket(st_startofpacket),
    .st_endofpacket(st_endofpacket)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  logic [DATA_W-1:0] mem_model [MEM_WORDS];
  beat_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  int     tests = 0;
  int     fails = 0;
  int     ready_mode = 0;
  bit     model_busy = 0;
  bit     pend_done = 0;
  int     issued = 0;
  int     accepted = 0;
  longint cyc = 0;
  longint first_acc_cyc = 0;
  longint last_acc_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory with one cycle of latency
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= mem_model[mem_address];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (tests=%0d)", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       st_ready = 1'b1;
        1:       st_ready = 1'($urandom_range(0, 1));
        default: st_ready = 1'b0;
      endcase
    end
  end

  // Monitor and reference model, evaluated once per cycle on the falling edge
  initial begin : monitor
    bit                busy_now;
    bit                next_done;
    bit                stall_prev;
    logic [DATA_W-1:0] stall_data;
    bit                lat_arm;
    int                lat_cnt;
    beat_t             e;
    logic [ADDR_W-1:0] a;
    stall_prev = 0;
    stall_data = '0;
    lat_arm    = 0;
    lat_cnt    = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        model_busy = 0; pend_done = 0; issued = 0; accepted = 0;
        stall_prev = 0; lat_arm = 0;
        continue;
      end
      busy_now = model_busy;
      check("busy", busy, busy_now);
      if (done || pend_done) check("done", done, pend_done);
      check("mem_clken", mem_clken, 1);
      if (mem_chipselect) begin
        if (addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL read_extra: read at 0x%0h, expected no read", mem_address);
        end else begin
          check("read_addr", mem_address, addr_q.pop_front());
        end
        check("outstanding_within_depth", (issued - accepted) < FIFO_DEPTH, 1);
        issued++;
      end
      if (stall_prev) begin
        check("stall_valid", st_valid, 1);
        check("stall_data", st_data, stall_data);
      end
      if (lat_arm) begin
        lat_cnt++;
        if (st_valid) begin
          check("first_valid_latency", lat_cnt <= 3, 1);
          lat_arm = 0;
        end else if (lat_cnt > 3) begin
          check("first_valid_latency", 0, 1);
          lat_arm = 0;
        end
      end
      next_done = 0;
      if (st_valid && st_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL beat_extra: got data 0x%0h, expected no beat", st_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", st_data, e.data);
          check("beat_sop", st_startofpacket, e.sop);
          check("beat_eop", st_endofpacket, e.eop);
          if (e.sop) first_acc_cyc = cyc;
          if (e.eop) begin
            last_acc_cyc = cyc;
            next_done    = 1;
            model_busy   = 0;
          end
        end
        accepted++;
      end
      stall_prev = st_valid && !st_ready;
      stall_data = st_data;
      if (start && !busy_now) begin
        if (length == 0) begin
          next_done = 1;
        end else begin
          for (int i = 0; i < int'(length); i++) begin
            a = base_addr + ADDR_W'(i);
            addr_q.push_back(a);
            exp_q.push_back('{data: mem_model[a], sop: (i == 0), eop: (i == int'(length) - 1)});
          end
          model_busy = 1;
          lat_arm    = 1;
          lat_cnt    = 0;
        end
      end
      pend_done = next_done;
    end
  end

  task automatic do_start(input int base, input int len);
    @(posedge clk);
    #1;
    base_addr = ADDR_W'(base);
    length    = (ADDR_W+1)'(len);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || model_busy || pend_done) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL %s_timeout: %0d beats still pending, expected 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_chipselect", mem_chipselect, 0);
    check("rst_st_valid", st_valid, 0);
    check("rst_st_sop", st_startofpacket, 0);
    check("rst_st_eop", st_endofpacket, 0);
    check("rst_st_data", st_data, 0);
  endtask

  initial begin : stimulus
    int n;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    reset_n   = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) mem_model[i] = $urandom;
    for (int i = 0; i < 4; i++) mem_model[16 + i] = DATA_W'(16 + i);
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic four-word transfer, memory word n holds n
    ready_mode = 0;
    do_start(16'h0010, 4);
    wait_idle("basic", 100);

    // Address wrap at the top of memory
    do_start(16'h3FFE, 4);
    wait_idle("wrap", 100);

    // Backpressure: random ready with a ten-cycle hold-off
    ready_mode = 1;
    do_start(16'h0100, 16);
    repeat (3) @(posedge clk);
    ready_mode = 2;
    repeat (10) @(posedge clk);
    ready_mode = 1;
    wait_idle("stall", 500);

    // Zero length, then a start while busy that must be ignored
    ready_mode = 0;
    do_start(16'h0200, 0);
    wait_idle("zero_len", 20);
    ready_mode = 1;
    do_start(16'h0300, 5);
    repeat (2) @(posedge clk);
    do_start(16'h0400, 3);
    wait_idle("start_while_busy", 200);

    // Reset in the middle of a transfer, then a fresh short transfer
    ready_mode = 0;
    do_start(16'h0500, 8);
    n = 0;
    while (exp_q.size() > 5 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL reset_mid_wait: %0d beats pending, expected 5", exp_q.size());
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    do_start(16'h0600, 2);
    wait_idle("after_reset", 100);

    // Random transfers with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 8; t++) begin
      do_start(int'($urandom_range(0, MEM_WORDS - 1)), int'($urandom_range(1, 40)));
      wait_idle("random", 2000);
    end

    // Full-memory transfer at one beat per cycle
    ready_mode = 0;
    do_start(16'h1234, MEM_WORDS);
    wait_idle("full", MEM_WORDS + 100);
    check("full_throughput_span", 64'(last_acc_cyc - first_acc_cyc), 64'(MEM_WORDS - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onchip_mem_stream_reader.md
ONCHIP_MEM_STREAM_READER -- requirements
Module: onchip_mem_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of the attached on-chip memory.
REQ-002 SHALL have parameter DATA_W, default 32, memory word and stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of 2, >= 4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr  input  ADDR_W  first word address, sampled with start.
REQ-008 SHALL have port length  input  ADDR_W+1  word count 0..2^ADDR_W, sampled with start.
REQ-009 SHALL have port busy  output  1  transfer in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_address  output  ADDR_W  memory word address.
REQ-012 SHALL have port mem_chipselect  output  1  read issue strobe.
REQ-013 SHALL have port mem_clken  output  1  memory clock enable, tied high.
REQ-014 SHALL have port mem_readdata  input  DATA_W  memory read data.
REQ-015 SHALL have ports st_data (output, DATA_W), st_valid (output, 1), st_ready (input, 1), st_startofpacket (output, 1), st_endofpacket (output, 1): Avalon-ST source, ready latency 0.

Function
REQ-016 SHALL be in IDLE or RUN state; IDLE->RUN on start with length>0 and busy low; RUN->IDLE the cycle after the last beat is accepted.
REQ-017 SHALL ignore start while busy is high.
REQ-018 SHALL, on start with length=0, stay in IDLE, issue no reads, pulse done the next cycle.
REQ-019 SHALL assert busy from the cycle after start is sampled until the cycle done pulses, inclusive of neither done cycle (busy low when done high).
REQ-020 SHALL issue one read per cycle with mem_chipselect high only while RUN, words remaining to issue > 0, and (fifo_count + reads_in_flight) < FIFO_DEPTH.
REQ-021 SHALL treat memory read latency as exactly 1 cycle: mem_readdata captured into the FIFO on the edge ending the cycle after the issue cycle.
REQ-022 SHALL increment mem_address by 1 per issued read, wrapping 2^ADDR_W-1 -> 0.
REQ-023 SHALL present st_data/st_valid from a registered FIFO head; a beat transfers when st_valid and st_ready are both high.
REQ-024 SHALL hold st_data and st_valid stable while st_valid is high and st_ready low.
REQ-025 SHALL assert st_startofpacket on the first beat and st_endofpacket on beat number length; both high for length=1.
REQ-026 SHALL never overflow the FIFO nor drop or reorder words; simultaneous FIFO push and pop SHALL leave count unchanged.
REQ-027 SHALL sustain one beat per cycle when st_ready is held high; first st_valid no later than 3 cycles after start is sampled.
REQ-028 SHALL drive mem_clken constantly 1 and never write memory.

Reset
REQ-029 SHALL, on reset_n low, immediately force IDLE, flush FIFO and in-flight count, and drive busy=0, done=0, mem_chipselect=0, mem_address=0, st_valid=0, st_startofpacket=0, st_endofpacket=0, st_data=0.
REQ-030 SHALL, after reset mid-transfer, discard the aborted transfer entirely and emit no done pulse for it.

Verification
REQ-031 base_addr=0x0010, length=4, st_ready=1, memory word n = n -> beats 0x10,0x11,0x12,0x13; sop on 0x10, eop on 0x13; done one cycle after last beat.
REQ-032 base_addr=0x3FFE, length=4 -> reads 0x3FFE,0x3FFF,0x0000,0x0001 in order.
REQ-033 length=16, st_ready toggled random, held low 10 cycles -> no more than FIFO_DEPTH reads outstanding+buffered, 16 beats exact, data stable during stall.
REQ-034 length=0 -> mem_chipselect never high, done pulses cycle after start, busy stays 0; start during busy -> ignored, single transfer completes.
REQ-035 reset_n low after 3 beats of length=8 -> all outputs at reset values same cycle; new start length=2 -> exactly 2 beats, fresh sop.
REQ-036 length=16384, st_ready=1 -> 16384 beats at 1/cycle, eop only on last, done once.
